// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache (8 blocks x 4 bytes).
// A three-state controller moves whole blocks to and from data memory.
module dcache_controller #(
  parameter int unsigned MISS_CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [7:0]            ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [5:0]            MEM_ADDRESS,
  output logic [31:0]           MEM_WRITEDATA,
  input  logic [31:0]           MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic [MISS_CNT_W-1:0] MISS_COUNT
);

  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BLK_W      = 32;
  localparam int unsigned MADDR_W    = TAG_W + IDX_W;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WRITE_BACK = 2'd1,
    S_FETCH      = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    first_q, first_d;
  logic [MISS_CNT_W-1:0]   miss_q, miss_d;
  logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
  logic [NUM_BLOCKS-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
  logic [BLK_W-1:0]        data_q [NUM_BLOCKS];

  logic [TAG_W-1:0]        addr_tag;
  logic [IDX_W-1:0]        addr_idx;
  logic [OFF_W-1:0]        addr_off;
  logic [BLK_W-1:0]        blk_sel;
  logic                    req;
  logic                    in_idle;
  logic                    hit;
  logic                    read_hit;
  logic                    write_hit;
  logic                    mem_done;
  logic                    fill_en;

  assign addr_tag = ADDRESS[7:5];
  assign addr_idx = ADDRESS[4:2];
  assign addr_off = ADDRESS[1:0];
  assign blk_sel  = data_q[addr_idx];

  // Hit detection is only meaningful in IDLE; simultaneous READ/WRITE is a store.
  assign req       = READ | WRITE;
  assign in_idle   = (state_q == S_IDLE);
  assign hit       = valid_q[addr_idx] & (tag_q[addr_idx] == addr_tag);
  assign read_hit  = RESET & in_idle & hit & READ & ~WRITE;
  assign write_hit = RESET & in_idle & hit & WRITE;

  // The first cycle of each transfer ignores the memory's busy flag.
  assign mem_done = ~first_q & ~MEM_BUSYWAIT;

  always_comb begin
    state_d = state_q;
    first_d = 1'b0;
    miss_d  = miss_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    fill_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          state_d = (valid_q[addr_idx] && dirty_q[addr_idx]) ? S_WRITE_BACK : S_FETCH;
          first_d = 1'b1;
          if (!(&miss_q)) begin
            miss_d = miss_q + MISS_CNT_W'(1);
          end
        end else if (write_hit) begin
          dirty_d[addr_idx] = 1'b1;
        end
      end
      S_WRITE_BACK: begin
        if (mem_done) begin
          dirty_d[addr_idx] = 1'b0;
          state_d           = S_FETCH;
          first_d           = 1'b1;
        end
      end
      S_FETCH: begin
        if (mem_done) begin
          fill_en           = 1'b1;
          valid_d[addr_idx] = 1'b1;
          dirty_d[addr_idx] = 1'b0;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      miss_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge CLK) begin
    if (fill_en) begin
      tag_q[addr_idx]  <= addr_tag;
      data_q[addr_idx] <= MEM_READDATA;
    end else if (write_hit) begin
      data_q[addr_idx][{addr_off, 3'b000} +: BYTE_W] <= WRITEDATA;
    end
  end

  always_comb begin
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      S_WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = MADDR_W'({tag_q[addr_idx], addr_idx});
        MEM_WRITEDATA = blk_sel;
      end
      S_FETCH: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = MADDR_W'({addr_tag, addr_idx});
      end
      default: ;
    endcase
  end

  assign BUSYWAIT   = RESET & req & ~(in_idle & hit);
  assign READDATA   = read_hit ? blk_sel[{addr_off, 3'b000} +: BYTE_W] : 8'h00;
  assign MISS_COUNT = miss_q;

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a latency-programmable memory model.
module tb_dcache_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [7:0]  ADDRESS = 8'h00;
  logic [7:0]  WRITEDATA = 8'h00;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [15:0] MISS_COUNT;

  int          checks = 0;
  int          errors = 0;

  // Memory model: busy for mem_lat cycles from the start of each transfer.
  int          mem_lat = 1;
  logic [31:0] mem_data = 32'h0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  int          xfer_cnt = 0;
  int          cnt_eff;
  logic        new_xfer;

  dcache_controller #(.MISS_CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .MISS_COUNT(MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    new_xfer     = (MEM_READ && !prev_rd) || (MEM_WRITE && !prev_wr);
    cnt_eff      = new_xfer ? 0 : xfer_cnt;
    MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (cnt_eff < mem_lat);
    MEM_READDATA = mem_data;
  end

  always @(posedge CLK) begin
    prev_rd  <= MEM_READ;
    prev_wr  <= MEM_WRITE;
    xfer_cnt <= cnt_eff + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for BUSYWAIT to drop, counting cycles spent in each transfer.
  task automatic wait_not_busy(input string tag, input int budget,
                               output int rd_cyc, output int wr_cyc);
    bit done = 1'b0;
    rd_cyc = 0;
    wr_cyc = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge CLK); #1;
      if (!BUSYWAIT) done = 1'b1;
      else begin
        if (MEM_READ)  rd_cyc++;
        if (MEM_WRITE) wr_cyc++;
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  int rd_c, wr_c, bad;
  bit seen;

  initial begin
    // Reset, with a request held to prove BUSYWAIT is forced low.
    READ = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_readdata", 32'(READDATA), 32'h00);
    check("rst_mem_read", 32'(MEM_READ), 32'd0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    check("rst_mem_addr", 32'(MEM_ADDRESS), 32'h00);
    check("rst_miss", 32'(MISS_COUNT), 32'd0);
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;

    // Clean read miss at 0x00, memory busy for 5 cycles.
    @(negedge CLK);
    mem_lat = 5; mem_data = 32'hDDCCBBAA;
    READ = 1'b1; ADDRESS = 8'h00;
    #1 check("t1_miss_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    check("t1_mem_read", 32'(MEM_READ), 32'd1);
    check("t1_mem_write", 32'(MEM_WRITE), 32'd0);
    check("t1_mem_addr", 32'(MEM_ADDRESS), 32'h00);
    check("t1_miss", 32'(MISS_COUNT), 32'd1);
    wait_not_busy("t1", 50, rd_c, wr_c);
    check("t1_fetch_cycles", 32'(rd_c), 32'd6);
    check("t1_wb_cycles", 32'(wr_c), 32'd0);
    check("t1_readdata", 32'(READDATA), 32'hAA);

    // Read hit right after the fill.
    @(negedge CLK);
    ADDRESS = 8'h01;
    #1;
    check("t2_readdata", 32'(READDATA), 32'hBB);
    check("t2_busy", 32'(BUSYWAIT), 32'd0);
    @(posedge CLK); #1;
    check("t2_mem_read", 32'(MEM_READ), 32'd0);
    check("t2_miss", 32'(MISS_COUNT), 32'd1);

    // Write hit makes block 0 dirty; conflicting read forces a write-back.
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h02; WRITEDATA = 8'h55;
    #1;
    check("t3_wr_busy", 32'(BUSYWAIT), 32'd0);
    check("t3_wr_readdata", 32'(READDATA), 32'h00);
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h22;
    mem_lat = 2; mem_data = 32'h44332211;
    #1 check("t3_miss_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    check("t3_mem_write", 32'(MEM_WRITE), 32'd1);
    check("t3_mem_read", 32'(MEM_READ), 32'd0);
    check("t3_wb_addr", 32'(MEM_ADDRESS), 32'h00);
    check("t3_wb_data", MEM_WRITEDATA, 32'hDD55BBAA);
    check("t3_miss", 32'(MISS_COUNT), 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge CLK); #1;
      if (MEM_READ) seen = 1'b1;
    end
    check("t3_fetch_seen", 32'(seen), 32'd1);
    check("t3_fetch_addr", 32'(MEM_ADDRESS), 32'h08);
    check("t3_fetch_nowr", 32'(MEM_WRITE), 32'd0);
    wait_not_busy("t3", 50, rd_c, wr_c);
    check("t3_readdata", 32'(READDATA), 32'h33);
    check("t3_miss_after", 32'(MISS_COUNT), 32'd2);

    // Write miss on an invalid entry: single fetch, then the store merges.
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'hE7; WRITEDATA = 8'h9C;
    mem_lat = 3; mem_data = 32'h00000000;
    #1 check("t4_miss_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    check("t4_mem_read", 32'(MEM_READ), 32'd1);
    check("t4_mem_addr", 32'(MEM_ADDRESS), 32'h39);
    check("t4_miss", 32'(MISS_COUNT), 32'd3);
    wait_not_busy("t4", 50, rd_c, wr_c);
    check("t4_wb_cycles", 32'(wr_c), 32'd0);
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1;
    #1;
    check("t4_readback", 32'(READDATA), 32'h9C);
    check("t4_hit_busy", 32'(BUSYWAIT), 32'd0);
    // Conflicting read on the same index proves the entry went dirty.
    @(negedge CLK);
    ADDRESS = 8'h07; mem_lat = 1; mem_data = 32'h0A0B0C0D;
    #1 check("t4b_miss_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    check("t4b_mem_write", 32'(MEM_WRITE), 32'd1);
    check("t4b_wb_addr", 32'(MEM_ADDRESS), 32'h39);
    check("t4b_wb_data", MEM_WRITEDATA, 32'h9C000000);
    check("t4b_miss", 32'(MISS_COUNT), 32'd4);
    wait_not_busy("t4b", 50, rd_c, wr_c);
    check("t4b_wb_cycles", 32'(wr_c), 32'd2);
    check("t4b_fetch_cycles", 32'(rd_c), 32'd2);
    check("t4b_readdata", 32'(READDATA), 32'h0A);
    // Dirty block 1 again before the reset test.
    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b1; WRITEDATA = 8'h5A;
    #1 check("t4c_wr_busy", 32'(BUSYWAIT), 32'd0);

    // Reset in the middle of a fetch.
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h41; mem_lat = 10;
    @(posedge CLK); #1;
    check("t5_mem_read", 32'(MEM_READ), 32'd1);
    check("t5_miss", 32'(MISS_COUNT), 32'd5);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("t5_rst_mem_read", 32'(MEM_READ), 32'd0);
    check("t5_rst_miss", 32'(MISS_COUNT), 32'd0);
    check("t5_rst_busy", 32'(BUSYWAIT), 32'd0);

    // Re-miss at 0x01 with memory held busy for 100 cycles.
    @(negedge CLK);
    RESET = 1'b1; ADDRESS = 8'h01; mem_lat = 100; mem_data = 32'h87654321;
    #1 check("t6_miss_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    check("t6_mem_read", 32'(MEM_READ), 32'd1);
    check("t6_miss", 32'(MISS_COUNT), 32'd1);
    bad = 0;
    for (int i = 0; i < 99; i++) begin
      @(negedge CLK); #1;
      if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b1 || MEM_WRITE !== 1'b0 ||
          MEM_ADDRESS !== 6'h00) bad++;
    end
    check("t6_hold_stable", 32'(bad), 32'd0);
    wait_not_busy("t6", 20, rd_c, wr_c);
    check("t6_readdata", 32'(READDATA), 32'h43);

    // READ and WRITE together on a hit act as a store.
    @(negedge CLK);
    WRITE = 1'b1; ADDRESS = 8'h03; WRITEDATA = 8'h77;
    #1;
    check("t7_rw_readdata", 32'(READDATA), 32'h00);
    check("t7_rw_busy", 32'(BUSYWAIT), 32'd0);
    @(negedge CLK);
    WRITE = 1'b0;
    #1;
    check("t7_readback", 32'(READDATA), 32'h77);
    check("t7_miss", 32'(MISS_COUNT), 32'd1);

    // Block 1 was dirty before reset: it must now be a plain fetch.
    @(negedge CLK);
    ADDRESS = 8'h07; mem_lat = 1; mem_data = 32'hCAFEF00D;
    #1 check("t8_miss_busy", 32'(BUSYWAIT), 32'd1);
    @(posedge CLK); #1;
    check("t8_mem_read", 32'(MEM_READ), 32'd1);
    check("t8_mem_write", 32'(MEM_WRITE), 32'd0);
    check("t8_miss", 32'(MISS_COUNT), 32'd2);
    wait_not_busy("t8", 20, rd_c, wr_c);
    check("t8_readdata", 32'(READDATA), 32'hCA);

    @(negedge CLK);
    READ = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
